binfo_resolve: RTL
==================

BINFO_RESOLVE -- requirements
Module: binfo_resolve

Interface
REQ-001 SHALL have parameter UPD_DEPTH, default 2, meaning the number of entries in the predictor-update FIFO (power of two, at least 2).
REQ-002 SHALL have port cpu_clock_i, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port cpu_resetn_i, input, 1 bit: reset, synchronous and active-low.
REQ-004 SHALL have port ex_vld_i, input, 1 bit: a resolved branch is presented by the execute unit.
REQ-005 SHALL have port ex_pack_i, input, 4 bits: the branch-info pack index of that branch.
REQ-006 SHALL have port ex_taken_i, input, 1 bit: the actual branch direction.
REQ-007 SHALL have port ex_target_i, input, 32 bits: the actual taken target.
REQ-008 SHALL have port ex_rdy_o, output, 1 bit: the block accepts the branch this cycle.
REQ-009 SHALL have port flush_i, input, 1 bit: pipeline flush.
REQ-010 SHALL have port pack_o, output, 4 bits: the branch-info RAM read index, driven combinationally from ex_pack_i.
REQ-011 SHALL have ports pc_i (32), bm_pred_i (2), btype_i (2), btb_vld_i (1), btb_target_i (32), btb_correct_i (1), btb_way_i (1), btb_idx_i (1), all inputs: the asynchronous read data for pack_o.
REQ-012 SHALL have port redirect_vld_o, output, 1 bit: one-cycle mispredict pulse.
REQ-013 SHALL have port redirect_pc_o, output, 32 bits: the correct fetch address.
REQ-014 SHALL have port upd_vld_o, output, 1 bit: the predictor-update FIFO head is valid.
REQ-015 SHALL have port upd_rdy_i, input, 1 bit: the BTB/BHT consumer accepts the head.
REQ-016 SHALL have update payload outputs upd_pc_o (32), upd_target_o (32), upd_taken_o (1), upd_bm_o (2), upd_btype_o (2), upd_way_o (1), upd_idx_o (1), upd_alloc_o (1).
REQ-017 SHALL have port mispred_cnt_o, output, 32 bits: the count of mispredicts.

Function
REQ-018 SHALL encode btype as 00 conditional, 01 jal, 10 jalr, 11 return.
REQ-019 SHALL accept a branch (handshake) only when ex_vld_i and ex_rdy_o are both high in the same cycle.
REQ-020 SHALL, on a handshake, register ex_taken_i, ex_target_i and all binfo read data into stage S1 (S1 valid next cycle); latency is 1 cycle from accept to redirect or FIFO push.
REQ-021 SHALL compute predicted-taken as btb_vld AND (btype != 00 OR bm_pred[1]).
REQ-022 SHALL compute predicted-next as btb_target when predicted-taken, else pc+4, with 32-bit wrap-around.
REQ-023 SHALL compute actual-next as ex_target when taken, else pc+4, with 32-bit wrap-around.
REQ-024 SHALL treat the branch as mispredicted when predicted-next != actual-next.
REQ-025 SHALL, when S1 is valid and mispredicted, drive redirect_vld_o high for exactly one cycle with redirect_pc_o = actual-next.
REQ-026 SHALL increment mispred_cnt_o by 1 on each redirect, wrapping from 0xFFFFFFFF to 0.
REQ-027 SHALL push every valid S1 branch into the FIFO.
REQ-028 SHALL form the FIFO entry as upd_pc = pc, upd_target = ex_target, upd_taken = taken, upd_way/idx = btb_way/idx, upd_btype = btype, and upd_alloc = NOT btb_vld AND taken.
REQ-029 SHALL set upd_bm, for btype 00, to the 2-bit saturating counter stepped toward the actual direction (3 stays 3 when taken, 0 stays 0 when not taken); for other btypes upd_bm = 2'b11.
REQ-030 SHALL pop the FIFO when upd_vld_o and upd_rdy_i are both high; payload and upd_vld_o SHALL be held stable while upd_vld_o=1 and upd_rdy_i=0.
REQ-031 SHALL drive ex_rdy_o = (fifo_count + S1_valid) < UPD_DEPTH AND NOT flush_i, so no entry is ever dropped on a full FIFO.
REQ-032 SHALL allow push and pop in the same cycle; count is unchanged and order is preserved (FIFO order = accept order).
REQ-033 SHALL, on flush_i, invalidate S1 in that cycle, suppress any redirect, push and counter increment from S1, and accept nothing; FIFO contents are kept and continue draining.
REQ-034 SHALL, when flush_i and a mispredicting S1 occur in the same cycle, let the flush win (redirect_vld_o=0).
REQ-035 SHALL ignore btb_correct_i for decisions.

Reset
REQ-036 SHALL, when cpu_resetn_i=0 at a clock edge, clear S1 valid, empty the FIFO and zero mispred_cnt_o; redirect_vld_o=0, upd_vld_o=0, ex_rdy_o=1 the cycle after; payload outputs are don't-care while invalid.
REQ-037 SHALL discard reset taken mid-operation (S1 valid, FIFO non-empty) without issuing a redirect or update.

Verification
REQ-038 Cond branch, pc=0x1000, btb_vld=1, bm=10, btb_target=0x2000, taken=1, target=0x2000 -> no redirect; one update: bm=11, alloc=0.
REQ-039 Same branch with taken=0 -> redirect_vld_o 1 cycle later, redirect_pc_o=0x1004, mispred_cnt_o=1, update bm=01.
REQ-040 jal, btb_vld=0, taken=1, target=0x3000 -> redirect to 0x3000, upd_alloc=1, upd_bm=11.
REQ-041 upd_rdy_i=0 with 3 branches offered back-to-back -> ex_rdy_o falls after 2 accepts; 3rd accepted only after upd_rdy_i=1; 3 updates delivered in order.
REQ-042 Mispredicting S1 with flush_i=1 the same cycle -> no redirect, no push, mispred_cnt_o unchanged.
REQ-043 pc=0xFFFFFFFC, cond, taken=0, btb predicted taken -> redirect_pc_o=0x00000000.

Source files
------------

// File: rtl/binfo_resolve.sv
// Branch resolution: compares the resolved direction and target of an executed
// branch against what the front end predicted, raises a one-cycle redirect on a
// mispredict, counts mispredicts, and queues a predictor update (BTB/BHT) for
// every resolved branch in a small in-order FIFO.
module binfo_resolve #(
    parameter int UPD_DEPTH = 2
) (
    input  logic        cpu_clock_i,
    input  logic        cpu_resetn_i,
    input  logic        ex_vld_i,
    input  logic [3:0]  ex_pack_i,
    input  logic        ex_taken_i,
    input  logic [31:0] ex_target_i,
    output logic        ex_rdy_o,
    input  logic        flush_i,
    output logic [3:0]  pack_o,
    input  logic [31:0] pc_i,
    input  logic [1:0]  bm_pred_i,
    input  logic [1:0]  btype_i,
    input  logic        btb_vld_i,
    input  logic [31:0] btb_target_i,
    input  logic        btb_correct_i,
    input  logic        btb_way_i,
    input  logic        btb_idx_i,
    output logic        redirect_vld_o,
    output logic [31:0] redirect_pc_o,
    output logic        upd_vld_o,
    input  logic        upd_rdy_i,
    output logic [31:0] upd_pc_o,
    output logic [31:0] upd_target_o,
    output logic        upd_taken_o,
    output logic [1:0]  upd_bm_o,
    output logic [1:0]  upd_btype_o,
    output logic        upd_way_o,
    output logic        upd_idx_o,
    output logic        upd_alloc_o,
    output logic [31:0] mispred_cnt_o
);

    localparam int PTR_W = $clog2(UPD_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int OCC_W = CNT_W + 1;
    localparam logic [1:0] BT_COND = 2'b00;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] target;
        logic        taken;
        logic [1:0]  bm;
        logic [1:0]  btype;
        logic        way;
        logic        idx;
        logic        alloc;
    } upd_t;

    // Two-bit bimodal counter stepped one position toward the actual outcome,
    // pinned at both ends.
    function automatic logic [1:0] sat_step(input logic [1:0] bm, input logic taken);
        logic [1:0] res;
        res = bm;
        if (taken) begin
            if (bm != 2'b11) res = bm + 2'b01;
        end else begin
            if (bm != 2'b00) res = bm - 2'b01;
        end
        return res;
    endfunction

    // Control state
    logic             r_vld_p1;
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic [31:0]      r_mispred_cnt;

    // Stage S1 data (no reset: qualified by r_vld_p1)
    logic [31:0] r_pc_p1;
    logic [1:0]  r_bm_p1;
    logic [1:0]  r_btype_p1;
    logic        r_btb_vld_p1;
    logic [31:0] r_btb_target_p1;
    logic        r_way_p1;
    logic        r_idx_p1;
    logic        r_taken_p1;
    logic [31:0] r_target_p1;

    upd_t r_mem [UPD_DEPTH];

    logic [OCC_W-1:0] w_occupancy;
    logic             w_accept;
    logic [31:0]      w_seq_pc;
    logic             w_pred_taken;
    logic [31:0]      w_pred_next;
    logic [31:0]      w_act_next;
    logic             w_mispred;
    logic             w_s1_live;
    logic             w_push;
    logic             w_pop;
    upd_t             w_push_entry;
    upd_t             w_head;
    logic             w_unused_btb_correct;

    // The prediction-correct hint from the BTB plays no part in the decision.
    assign w_unused_btb_correct = btb_correct_i;

    assign pack_o = ex_pack_i;

    // Anything in S1 is guaranteed a FIFO slot, so accept only while the
    // FIFO plus S1 leaves room for one more branch.
    assign w_occupancy = {1'b0, r_count} + OCC_W'(r_vld_p1);
    assign ex_rdy_o    = (w_occupancy < OCC_W'(UPD_DEPTH)) && !flush_i;
    assign w_accept    = ex_vld_i && ex_rdy_o;

    // ---- S1: resolve against the prediction ----
    assign w_seq_pc     = r_pc_p1 + 32'd4;
    assign w_pred_taken = r_btb_vld_p1 && ((r_btype_p1 != BT_COND) || r_bm_p1[1]);
    assign w_pred_next  = w_pred_taken ? r_btb_target_p1 : w_seq_pc;
    assign w_act_next   = r_taken_p1 ? r_target_p1 : w_seq_pc;
    assign w_mispred    = (w_pred_next != w_act_next);

    // A flush or a reset in the same cycle kills S1 before it has any effect.
    assign w_s1_live      = r_vld_p1 && !flush_i && cpu_resetn_i;
    assign redirect_vld_o = w_s1_live && w_mispred;
    assign redirect_pc_o  = w_act_next;
    assign mispred_cnt_o  = r_mispred_cnt;

    assign w_push    = w_s1_live;
    assign upd_vld_o = (r_count != '0);
    assign w_pop     = upd_vld_o && upd_rdy_i;

    // Build the predictor update record from the resolved S1 branch.
    always_comb begin
        w_push_entry        = '0;
        w_push_entry.pc     = r_pc_p1;
        w_push_entry.target = r_target_p1;
        w_push_entry.taken  = r_taken_p1;
        w_push_entry.bm     = (r_btype_p1 == BT_COND) ? sat_step(r_bm_p1, r_taken_p1) : 2'b11;
        w_push_entry.btype  = r_btype_p1;
        w_push_entry.way    = r_way_p1;
        w_push_entry.idx    = r_idx_p1;
        w_push_entry.alloc  = !r_btb_vld_p1 && r_taken_p1;
    end

    assign w_head       = r_mem[r_rd_ptr];
    assign upd_pc_o     = w_head.pc;
    assign upd_target_o = w_head.target;
    assign upd_taken_o  = w_head.taken;
    assign upd_bm_o     = w_head.bm;
    assign upd_btype_o  = w_head.btype;
    assign upd_way_o    = w_head.way;
    assign upd_idx_o    = w_head.idx;
    assign upd_alloc_o  = w_head.alloc;

    // S1 valid: set by an accepted branch, dropped otherwise.
    always_ff @(posedge cpu_clock_i) begin
        if (!cpu_resetn_i) begin
            r_vld_p1 <= 1'b0;
        end else begin
            r_vld_p1 <= w_accept;
        end
    end

    // S1 payload: capture execute result and branch-info read data on accept.
    always_ff @(posedge cpu_clock_i) begin
        if (w_accept) begin
            r_pc_p1         <= pc_i;
            r_bm_p1         <= bm_pred_i;
            r_btype_p1      <= btype_i;
            r_btb_vld_p1    <= btb_vld_i;
            r_btb_target_p1 <= btb_target_i;
            r_way_p1        <= btb_way_i;
            r_idx_p1        <= btb_idx_i;
            r_taken_p1      <= ex_taken_i;
            r_target_p1     <= ex_target_i;
        end
    end

    // FIFO storage: write the resolved update at the tail.
    always_ff @(posedge cpu_clock_i) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_push_entry;
        end
    end

    // FIFO pointers and occupancy; simultaneous push and pop leave count as is.
    always_ff @(posedge cpu_clock_i) begin
        if (!cpu_resetn_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Mispredict counter, wraps naturally at 32 bits.
    always_ff @(posedge cpu_clock_i) begin
        if (!cpu_resetn_i) begin
            r_mispred_cnt <= '0;
        end else if (redirect_vld_o) begin
            r_mispred_cnt <= r_mispred_cnt + 32'd1;
        end
    end

endmodule
